// File: rtl/x_prop_result_monitor.sv
// x_prop_result_monitor
//   Checker for a dual-rail (value + known-mask) result stream. Each accepted
//   sample is compared against an expected dual-rail word, and the monitor
//   keeps mismatch and unknown-bit statistics. After CYCLE_MAX samples the run
//   ends with done=1 and pass=(no mismatching sample).
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      begin a run (honoured in IDLE and DONE)
//   in_valid / in_ready        sample handshake, in_ready = state is RUN
//   in_value, in_known         result word; known=0 marks an X bit
//   exp_value, exp_known       expected word; exp_known=0 marks don't-care
//   sample_count               samples accepted this run
//   mismatch_count             samples with at least one failing bit (sat.)
//   x_sample_count             samples containing an X bit (sat.)
//   x_bit_total                total X bits seen this run (sat.)
//   first_mismatch_idx/_valid  0-based index of the first failing sample
//   done, pass                 run complete / run complete with no mismatch
module x_prop_result_monitor #(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] CYCLE_MAX = 32'd10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] in_known,
  input  logic [WIDTH-1:0] exp_value,
  input  logic [WIDTH-1:0] exp_known,
  output logic [31:0]      sample_count,
  output logic [15:0]      mismatch_count,
  output logic [15:0]      x_sample_count,
  output logic [31:0]      x_bit_total,
  output logic [31:0]      first_mismatch_idx,
  output logic             first_mismatch_valid,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [31:0] popcount(input logic [WIDTH-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic [15:0] mismatch_count_q, mismatch_count_d;
  logic [15:0] x_sample_count_q, x_sample_count_d;
  logic [31:0] x_bit_total_q, x_bit_total_d;
  logic [31:0] first_mismatch_idx_q, first_mismatch_idx_d;
  logic        first_mismatch_valid_q, first_mismatch_valid_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [WIDTH-1:0] fail_bits;
  logic             accept;

  // An X where a defined bit is expected fails; don't-care bits never fail.
  assign fail_bits = exp_known & (~in_known | (in_value ^ exp_value));
  assign in_ready  = (state_q == RUN);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d                = state_q;
    sample_count_d         = sample_count_q;
    mismatch_count_d       = mismatch_count_q;
    x_sample_count_d       = x_sample_count_q;
    x_bit_total_d          = x_bit_total_q;
    first_mismatch_idx_d   = first_mismatch_idx_q;
    first_mismatch_valid_d = first_mismatch_valid_q;
    done_d                 = done_q;
    pass_d                 = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sample_count_d         = '0;
          mismatch_count_d       = '0;
          x_sample_count_d       = '0;
          x_bit_total_d          = '0;
          first_mismatch_idx_d   = '0;
          first_mismatch_valid_d = 1'b0;
          // A zero-length run completes immediately and trivially passes.
          if (CYCLE_MAX == 32'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (accept) begin
          // sample_count stays below CYCLE_MAX while in RUN, so no overflow.
          sample_count_d = sample_count_q + 32'd1;
          if (|fail_bits) begin
            mismatch_count_d = sat_inc16(mismatch_count_q);
            if (!first_mismatch_valid_q) begin
              first_mismatch_idx_d   = sample_count_q;
              first_mismatch_valid_d = 1'b1;
            end
          end
          if (~&in_known) x_sample_count_d = sat_inc16(x_sample_count_q);
          x_bit_total_d = sat_add32(x_bit_total_q, popcount(~in_known));
          if (sample_count_d == CYCLE_MAX) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (mismatch_count_d == 16'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                <= IDLE;
      sample_count_q         <= '0;
      mismatch_count_q       <= '0;
      x_sample_count_q       <= '0;
      x_bit_total_q          <= '0;
      first_mismatch_idx_q   <= '0;
      first_mismatch_valid_q <= 1'b0;
      done_q                 <= 1'b0;
      pass_q                 <= 1'b0;
    end else begin
      state_q                <= state_d;
      sample_count_q         <= sample_count_d;
      mismatch_count_q       <= mismatch_count_d;
      x_sample_count_q       <= x_sample_count_d;
      x_bit_total_q          <= x_bit_total_d;
      first_mismatch_idx_q   <= first_mismatch_idx_d;
      first_mismatch_valid_q <= first_mismatch_valid_d;
      done_q                 <= done_d;
      pass_q                 <= pass_d;
    end
  end

  assign sample_count         = sample_count_q;
  assign mismatch_count       = mismatch_count_q;
  assign x_sample_count       = x_sample_count_q;
  assign x_bit_total          = x_bit_total_q;
  assign first_mismatch_idx   = first_mismatch_idx_q;
  assign first_mismatch_valid = first_mismatch_valid_q;
  assign done                 = done_q;
  assign pass                 = pass_q;

endmodule

// File: tb/tb_x_prop_result_monitor.sv
// Bench for x_prop_result_monitor: directed scenarios plus a randomized run,
// all checked against a run-level reference model (counts kept as integers).
module tb_x_prop_result_monitor;

  localparam int CMAX = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_value = '0, in_known = '0, exp_value = '0, exp_known = '0;

  logic        in_ready, first_mismatch_valid, done, pass;
  logic [31:0] sample_count, x_bit_total, first_mismatch_idx;
  logic [15:0] mismatch_count, x_sample_count;

  logic        z_in_ready, z_fmv, z_done, z_pass;
  logic [31:0] z_sample_count, z_x_bit_total, z_fmi;
  logic [15:0] z_mismatch_count, z_x_sample_count;

  x_prop_result_monitor #(.WIDTH(16), .CYCLE_MAX(32'd10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_known(in_known), .exp_value(exp_value), .exp_known(exp_known),
    .sample_count(sample_count), .mismatch_count(mismatch_count),
    .x_sample_count(x_sample_count), .x_bit_total(x_bit_total),
    .first_mismatch_idx(first_mismatch_idx), .first_mismatch_valid(first_mismatch_valid),
    .done(done), .pass(pass));

  x_prop_result_monitor #(.WIDTH(16), .CYCLE_MAX(32'd0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_value(in_value), .in_known(in_known), .exp_value(exp_value), .exp_known(exp_known),
    .sample_count(z_sample_count), .mismatch_count(z_mismatch_count),
    .x_sample_count(z_x_sample_count), .x_bit_total(z_x_bit_total),
    .first_mismatch_idx(z_fmi), .first_mismatch_valid(z_fmv),
    .done(z_done), .pass(z_pass));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = running, 2 = finished.
  int     m_state, m_samples, m_mis, m_xs, m_fidx;
  longint m_xbits;
  bit     m_fv;

  task automatic model_clear();
    m_samples = 0; m_mis = 0; m_xs = 0; m_xbits = 0; m_fidx = 0; m_fv = 0;
  endtask

  task automatic model_accept(input logic [15:0] v, k, ev, ek);
    bit bad = 0;
    for (int i = 0; i < 16; i++)
      if (ek[i] && (!k[i] || v[i] != ev[i])) bad = 1;
    if (bad && !m_fv) begin m_fidx = m_samples; m_fv = 1; end
    m_samples++;
    if (bad && m_mis < 65535) m_mis++;
    if (k != 16'hFFFF && m_xs < 65535) m_xs++;
    m_xbits = m_xbits + $countones(~k);
    if (m_xbits > 64'hFFFF_FFFF) m_xbits = 64'hFFFF_FFFF;
    if (m_samples == CMAX) m_state = 2;
  endtask

  // One clock: drive inputs at negedge, advance the model at the edge, return
  // just after the edge so outputs are sampled away from it.
  task automatic cycle(input logic s, input logic vld, input logic [15:0] v, k, ev, ek);
    @(negedge clk);
    start = s; in_valid = vld; in_value = v; in_known = k; exp_value = ev; exp_known = ek;
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; model_clear();
    end else if (m_state != 1) begin
      if (s) begin model_clear(); m_state = 1; end
    end else if (vld) begin
      model_accept(v, k, ev, ek);
    end
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'hFFFF);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b1;
    idle_cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (sample_count !== 32'd0) begin errors++; $display("FAIL reset_sample_count got=%0d exp=0", sample_count); end
    checks++; if (mismatch_count !== 16'd0 || x_sample_count !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", mismatch_count, x_sample_count); end
    checks++; if (x_bit_total !== 32'd0 || first_mismatch_idx !== 32'd0) begin errors++; $display("FAIL reset_xbits_idx got=%0d/%0d exp=0/0", x_bit_total, first_mismatch_idx); end
    checks++; if ({first_mismatch_valid, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {first_mismatch_valid, done, pass}); end
  endtask

  task automatic test_clean_run();
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready got=%b exp=1", in_ready); end
    checks++; if ({z_done, z_pass, z_in_ready} !== 3'b110 || z_sample_count !== 32'd0) begin errors++; $display("FAIL cmax0 got=%b cnt=%0d exp=110 cnt=0", {z_done, z_pass, z_in_ready}, z_sample_count); end
    for (int i = 0; i < CMAX; i++) begin
      cycle(1'b0, 1'b1, 16'h4200, 16'hFFFF, 16'h4200, 16'hFFFF);
      if (i == CMAX - 2) begin
        checks++; if (pass !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clean_early_done got=%b%b exp=00", done, pass); end
      end
    end
    checks++; if (sample_count !== 32'(m_samples) || mismatch_count !== 16'(m_mis)) begin errors++; $display("FAIL clean_counts got=%0d/%0d exp=%0d/%0d", sample_count, mismatch_count, m_samples, m_mis); end
    checks++; if ({done, pass, in_ready} !== 3'b110) begin errors++; $display("FAIL clean_done got=%b exp=110", {done, pass, in_ready}); end
    cycle(1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF);
    checks++; if (sample_count !== 32'd10 || mismatch_count !== 16'd0 || pass !== 1'b1) begin errors++; $display("FAIL drop_in_done got=%0d/%0d/%b exp=10/0/1", sample_count, mismatch_count, pass); end
    checks++; if (z_sample_count !== 32'd0 || z_done !== 1'b1) begin errors++; $display("FAIL cmax0_drop got=%0d/%b exp=0/1", z_sample_count, z_done); end
  endtask

  task automatic test_x_fail(input logic [15:0] ek_mask);
    logic [15:0] v;
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < CMAX; i++) begin
      v = 16'($urandom);
      cycle(1'b0, 1'b1, v, 16'h01FF, v ^ (16'($urandom) & ~ek_mask), ek_mask);
    end
    checks++; if (mismatch_count !== 16'(m_mis) || x_sample_count !== 16'(m_xs)) begin errors++; $display("FAIL x_counts ek=%h got=%0d/%0d exp=%0d/%0d", ek_mask, mismatch_count, x_sample_count, m_mis, m_xs); end
    checks++; if (x_bit_total !== 32'(m_xbits) || x_bit_total !== 32'd70) begin errors++; $display("FAIL x_bit_total ek=%h got=%0d exp=70", ek_mask, x_bit_total); end
    checks++; if (first_mismatch_valid !== m_fv || (m_fv && first_mismatch_idx !== 32'(m_fidx))) begin errors++; $display("FAIL x_first ek=%h got=%b/%0d exp=%b/%0d", ek_mask, first_mismatch_valid, first_mismatch_idx, m_fv, m_fidx); end
    checks++; if (pass !== (m_mis == 0) || done !== 1'b1) begin errors++; $display("FAIL x_pass ek=%h got=%b exp=%b", ek_mask, pass, m_mis == 0); end
  endtask

  task automatic test_gap_flip();
    logic [15:0] v;
    logic [31:0] held;
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < CMAX; i++) begin
      v = 16'($urandom);
      cycle(1'b0, 1'b1, v, 16'hFFFF, (i == 4) ? (v ^ 16'h0020) : v, 16'hFFFF);
      if (i == 6) begin
        held = sample_count;
        for (int g = 0; g < 3; g++) idle_cycle();
        checks++; if (sample_count !== held || sample_count !== 32'd7) begin errors++; $display("FAIL gap_hold got=%0d exp=7", sample_count); end
      end
    end
    checks++; if (mismatch_count !== 16'd1 || sample_count !== 32'd10) begin errors++; $display("FAIL flip_counts got=%0d/%0d exp=1/10", mismatch_count, sample_count); end
    checks++; if (first_mismatch_idx !== 32'(m_fidx) || m_fidx != 4 || first_mismatch_valid !== 1'b1) begin errors++; $display("FAIL flip_first got=%0d exp=4", first_mismatch_idx); end
  endtask

  task automatic test_reset_restart();
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h00F0, 16'h0FFF, 16'h00F1, 16'hFFFF);
    rst_n = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    checks++; if (sample_count !== 32'd0 || mismatch_count !== 16'd0 || x_bit_total !== 32'd0) begin errors++; $display("FAIL midrun_reset got=%0d/%0d/%0d exp=0/0/0", sample_count, mismatch_count, x_bit_total); end
    checks++; if ({in_ready, done, first_mismatch_valid} !== 3'b000) begin errors++; $display("FAIL midrun_flags got=%b exp=000", {in_ready, done, first_mismatch_valid}); end
    cycle(1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF);
    checks++; if (sample_count !== 32'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_drop got=%0d/%b exp=0/0", sample_count, in_ready); end
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < CMAX; i++) cycle(1'b0, 1'b1, 16'h0003, 16'hFFFF, 16'h0001, 16'hFFFF);
    checks++; if (done !== 1'b1 || pass !== 1'b0 || mismatch_count !== 16'd10) begin errors++; $display("FAIL run2 got=%b%b/%0d exp=10/10", done, pass, mismatch_count); end
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    checks++; if ({done, in_ready} !== 2'b01 || mismatch_count !== 16'd0 || first_mismatch_valid !== 1'b0) begin errors++; $display("FAIL restart got=%b/%0d exp=01/0", {done, in_ready}, mismatch_count); end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'hAAAA, 16'hFFFF, 16'hAAAA, 16'hFFFF);
    checks++; if (sample_count !== 32'(m_samples) || m_samples != 3 || in_ready !== 1'b1) begin errors++; $display("FAIL start_in_run got=%0d exp=3", sample_count); end
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 16'hAAAA, 16'hFFFF, 16'hAAAA, 16'hFFFF);
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL restart_done got=%b exp=11", {done, pass}); end
  endtask

  task automatic test_random();
    logic [15:0] v, k, ev, ek;
    logic s, vld;
    for (int c = 0; c < 300; c++) begin
      s   = ($urandom_range(0, 15) == 0);
      vld = ($urandom_range(0, 3) != 0);
      v   = 16'($urandom);
      k   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
      ek  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFFF;
      ev  = ($urandom_range(0, 3) == 0) ? (v ^ 16'(1 << $urandom_range(0, 15))) : v;
      cycle(s, vld, v, k, ev, ek);
      checks++;
      if (sample_count !== 32'(m_samples) || mismatch_count !== 16'(m_mis) || x_sample_count !== 16'(m_xs) || x_bit_total !== 32'(m_xbits)) begin
        errors++;
        $display("FAIL rnd_counts cyc=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c, sample_count, mismatch_count, x_sample_count, x_bit_total, m_samples, m_mis, m_xs, m_xbits);
      end
      checks++;
      if (first_mismatch_valid !== m_fv || (m_fv && first_mismatch_idx !== 32'(m_fidx))) begin
        errors++;
        $display("FAIL rnd_first cyc=%0d got=%b/%0d exp=%b/%0d", c, first_mismatch_valid, first_mismatch_idx, m_fv, m_fidx);
      end
      checks++;
      if (in_ready !== (m_state == 1) || done !== (m_state == 2) || pass !== (m_state == 2 && m_mis == 0)) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d got=%b%b%b exp=%b%b%b", c, in_ready, done, pass, m_state == 1, m_state == 2, m_state == 2 && m_mis == 0);
      end
    end
  endtask

  initial begin
    m_state = 0;
    model_clear();
    test_reset();
    test_clean_run();
    test_x_fail(16'hFFFF);
    test_x_fail(16'h01FF);
    test_gap_flip();
    test_reset_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
